// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM state, FIFO entry, widths.
package loader_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous capture FIFO; pointers carry an extra wrap bit.
module loader_fifo
  import loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output logic   last,
  output entry_t head
);

  localparam int IW = $clog2(FIFO_DEPTH);

  logic [IW:0] wp;
  logic [IW:0] rp;
  logic [IW:0] cnt;
  entry_t      mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp[IW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (pop)
        rp <= rp + 1'b1;
    end
  end

  assign cnt   = wp - rp;
  assign empty = (wp == rp);
  assign full  = (wp[IW] != rp[IW]) &&
                 (wp[IW-1:0] == rp[IW-1:0]);
  assign last  = (cnt == (IW+1)'(1));
  assign head  = mem[rp[IW-1:0]];

endmodule

// File: rtl/prog_loader.sv
// Captures receiver words into a FIFO and drains them to instruction memory.
// Optional running checksum: define PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int IMEM_AW    = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [DATA_W-1:0]  in_addr,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_wr,
  output logic [IMEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_we,
  input  logic               mem_ready,
  output logic               cpu_rst,
  output logic [CNT_W-1:0]   word_cnt,
  output logic [DATA_W-1:0]  checksum,
  output logic               ovf_err,
  output logic               range_err
);

  logic   in_wr_q;
  logic   load_en_q;
  logic   cap;
  logic   range_bad;
  logic   load_start;
  logic   push;
  logic   pop;
  logic   full;
  logic   empty;
  logic   last;
  entry_t din;
  entry_t head;
  state_t state;
  logic   unused_addr_hi;

  assign cap        = in_wr & ~in_wr_q & load_en;
  assign range_bad  = |(in_addr >> IMEM_AW);
  assign load_start = load_en & ~load_en_q;
  assign pop        = mem_we & mem_ready;
  assign push       = cap & ~range_bad & (~full | pop);

  assign din.addr = DATA_W'(in_addr[IMEM_AW-1:0]);
  assign din.data = in_data;

  loader_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .last  (last),
    .head  (head)
  );

  assign mem_addr       = head.addr[IMEM_AW-1:0];
  assign mem_wdata      = head.data;
  assign unused_addr_hi = ^head.addr[DATA_W-1:IMEM_AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      in_wr_q   <= 1'b0;
      load_en_q <= 1'b0;
    end else begin
      in_wr_q   <= in_wr;
      load_en_q <= load_en;
    end
  end

  // Drops low only when the entry being popped is the last one left.
  always_ff @(posedge clk) begin
    if (rst)
      mem_we <= 1'b0;
    else
      mem_we <= ~empty & ~(pop & ~push & last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HOLD;
      cpu_rst <= 1'b1;
    end else begin
      unique case (state)
        HOLD: begin
          if (!load_en && empty && !mem_we) begin
            state   <= RUN;
            cpu_rst <= 1'b0;
          end
        end
        RUN: begin
          if (load_en) begin
            state   <= HOLD;
            cpu_rst <= 1'b1;
          end
        end
        default: begin
          state   <= HOLD;
          cpu_rst <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt  <= '0;
      ovf_err   <= 1'b0;
      range_err <= 1'b0;
    end else begin
      word_cnt  <= (load_start ? '0 : word_cnt) + CNT_W'(pop);
      ovf_err   <= (ovf_err & ~load_start) |
                   (cap & ~range_bad & full & ~pop);
      range_err <= (range_err & ~load_start) |
                   (cap & range_bad);
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)
      checksum <= '0;
    else
      checksum <= (load_start ? '0 : checksum) +
                  (pop ? mem_wdata : '0);
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;
  import loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        in_wr;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_ready;
  logic        cpu_rst;
  logic [15:0] word_cnt;
  logic [31:0] checksum;
  logic        ovf_err;
  logic        range_err;

  int checks = 0;
  int failures = 0;
  logic [37:0] cq[$];

  always #5 clk = ~clk;

  prog_loader #(
    .IMEM_AW    (6),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_wr     (in_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .cpu_rst   (cpu_rst),
    .word_cnt  (word_cnt),
    .checksum  (checksum),
    .ovf_err   (ovf_err),
    .range_err (range_err)
  );

  // A commit happens at the next posedge when both are high mid-cycle.
  always @(negedge clk)
    if (!rst && mem_we && mem_ready)
      cq.push_back({mem_addr, mem_wdata});

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] a,
                           input logic [31:0] d);
    in_addr = a;
    in_data = d;
    in_wr   = 1'b1;
    tick();
    in_wr   = 1'b0;
    tick();
  endtask

  logic [31:0] exp_sum;
  int          c2_idx;
  int          fall_idx;
  int          early_rel;
  int          ncommit;

  initial begin
    rst = 1'b1;
    load_en = 1'b0;
    in_addr = '0;
    in_data = '0;
    in_wr = 1'b0;
    mem_ready = 1'b0;
    tick(2);

    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    chk("rst_flags", {30'd0, ovf_err, range_err}, 32'd0);

    // Load three words with memory always ready
    rst = 1'b0;
    load_en = 1'b1;
    mem_ready = 1'b1;
    tick();
    cq.delete();
    send_word(32'd0, 32'h13);
    send_word(32'd1, 32'h13);
    send_word(32'd2, 32'h13);
    tick(3);
    chk("t1_ncommit", 32'(cq.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < cq.size()) begin
        chk("t1_addr", 32'(cq[i][37:32]), 32'(i));
        chk("t1_data", cq[i][31:0], 32'h13);
      end
    end
    chk("t1_word_cnt", 32'(word_cnt), 32'd3);
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_sum = 32'h39;
`else
    exp_sum = 32'h0;
`endif
    chk("t1_checksum", checksum, exp_sum);
    chk("t1_cpu_hold", 32'(cpu_rst), 32'd1);
    load_en = 1'b0;
    tick();
    chk("t1_cpu_release", 32'(cpu_rst), 32'd0);

    // Long in_wr level gives one capture
    load_en = 1'b1;
    tick();
    chk("t2_cpu_rerst", 32'(cpu_rst), 32'd1);
    chk("t2_cnt_clear", 32'(word_cnt), 32'd0);
    cq.delete();
    in_addr = 32'd5;
    in_data = 32'hA5A5_0001;
    in_wr = 1'b1;
    tick(500);
    in_wr = 1'b0;
    tick(3);
    chk("t2_ncommit", 32'(cq.size()), 32'd1);
    chk("t2_word_cnt", 32'(word_cnt), 32'd1);

    // Stall memory while five words arrive
    mem_ready = 1'b0;
    cq.delete();
    for (int i = 0; i < 4; i++)
      send_word(32'(10 + i), 32'h100 + 32'(i));
    chk("t3_no_ovf", 32'(ovf_err), 32'd0);
    chk("t3_head_addr", 32'(mem_addr), 32'd10);
    send_word(32'd14, 32'h104);
    chk("t3_ovf", 32'(ovf_err), 32'd1);
    chk("t3_we_stall", 32'(mem_we), 32'd1);
    chk("t3_head_data", mem_wdata, 32'h100);
    mem_ready = 1'b1;
    tick(6);
    chk("t3_ncommit", 32'(cq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < cq.size()) begin
        chk("t3_addr", 32'(cq[i][37:32]), 32'(10 + i));
        chk("t3_data", cq[i][31:0], 32'h100 + 32'(i));
      end
    end
    chk("t3_word_cnt", 32'(word_cnt), 32'd5);

    // Out-of-range address
    load_en = 1'b0;
    tick();
    load_en = 1'b1;
    tick();
    chk("t4_ovf_clear", 32'(ovf_err), 32'd0);
    cq.delete();
    send_word(32'd64, 32'hDEAD_BEEF);
    tick(3);
    chk("t4_ncommit", 32'(cq.size()), 32'd0);
    chk("t4_we", 32'(mem_we), 32'd0);
    chk("t4_range", 32'(range_err), 32'd1);
    load_en = 1'b0;
    tick();
    load_en = 1'b1;
    tick();
    chk("t4_range_clear", 32'(range_err), 32'd0);

    // Drain after load_en drops, memory ready one cycle in three
    mem_ready = 1'b0;
    cq.delete();
    send_word(32'd20, 32'h200);
    send_word(32'd21, 32'h201);
    load_en = 1'b0;
    c2_idx = -1;
    fall_idx = -1;
    early_rel = 0;
    ncommit = 0;
    for (int k = 0; k < 30; k++) begin
      mem_ready = (k % 3 == 2);
      if (mem_we && mem_ready) begin
        ncommit++;
        if (ncommit == 2) c2_idx = k;
      end
      tick();
      if (!cpu_rst && fall_idx < 0) fall_idx = k;
      if (!cpu_rst && (c2_idx < 0 || k <= c2_idx)) early_rel++;
    end
    chk("t5_ncommit", 32'(cq.size()), 32'd2);
    if (cq.size() == 2) begin
      chk("t5_addr0", 32'(cq[0][37:32]), 32'd20);
      chk("t5_addr1", 32'(cq[1][37:32]), 32'd21);
    end
    chk("t5_early_release", 32'(early_rel), 32'd0);
    chk("t5_release_lat", 32'(fall_idx - c2_idx), 32'd1);

    // Reset during a drain
    load_en = 1'b1;
    mem_ready = 1'b0;
    tick();
    send_word(32'd30, 32'h300);
    send_word(32'd31, 32'h301);
    send_word(32'd32, 32'h302);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("t6_we", 32'(mem_we), 32'd0);
    chk("t6_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t6_word_cnt", 32'(word_cnt), 32'd0);
    chk("t6_checksum", checksum, 32'd0);
    chk("t6_mem_addr", 32'(mem_addr), 32'd0);
    chk("t6_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    mem_ready = 1'b1;
    cq.delete();
    tick(5);
    chk("t6_no_commit", 32'(cq.size()), 32'd0);
    chk("t6_cnt_after", 32'(word_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
